ex_muldiv_unit: RTL

//  Multi-cycle RV32M/RV64M execute unit beside the single-cycle ALU in the EX stage.
//  - Pipelined multiplier, iterative radix-2 divider, one operation in flight.
//  - valid/ready handshakes on both sides; flush input driven by the branch unit.
//  - EX stalls the front-end while busy=1.

---
 rtl/ex_muldiv_if.sv | 25 ++
 rtl/ex_muldiv_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_if.sv
// Issue/result handshake bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd_i;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_o;
  logic            busy;

  modport master (
    output in_valid, op, rs1, rs2, rd_i, flush, out_ready,
    input  in_ready, out_valid, result, rd_o, busy
  );

  modport slave (
    input  in_valid, op, rs1, rs2, rd_i, flush, out_ready,
    output in_ready, out_valid, result, rd_o, busy
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M/RV64M multi-cycle execute unit: pipelined multiply, radix-2 restoring divide.
// Define MULDIV_EARLY_OUT_EN to skip the dividend's leading zeros before iterating.
module ex_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, dvs;
    logic [CW-1:0]     cnt;
    logic              neg_q, neg_r;

    logic              signed_div, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] a_ext, b_ext, prod_in;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_diff;
    logic              step_ge;

`ifdef MULDIV_EARLY_OUT_EN
    function automatic int clz(input logic [XLEN-1:0] v);
        int n;
        n = XLEN;
        for (int i = 0; i < XLEN; i++)
            if (v[i]) n = XLEN - 1 - i;
        return n;
    endfunction
`endif

    assign bus.in_ready = (state == S_IDLE);
    assign bus.busy     = (state != S_IDLE);

    // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        signed_div = bus.op[2] & ~bus.op[0];
        sign_a     = signed_div & bus.rs1[XLEN-1];
        sign_b     = signed_div & bus.rs2[XLEN-1];
        mag_a      = sign_a ? -bus.rs1 : bus.rs1;
        mag_b      = sign_b ? -bus.rs2 : bus.rs2;
        // MULHU is the only op with an unsigned multiplicand; MULHSU/MULHU have unsigned multipliers.
        a_ext      = {{XLEN{(bus.op != 3'd3) & bus.rs1[XLEN-1]}}, bus.rs1};
        b_ext      = {{XLEN{~bus.op[1] & bus.rs2[XLEN-1]}}, bus.rs2};
        prod_in    = a_ext * b_ext;
        rem_sh     = {rem, quo[XLEN-1]};
        step_ge    = rem_sh >= {1'b0, dvs};
        rem_diff   = rem_sh[XLEN-1:0] - dvs;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            op_q          <= '0;
            prod          <= '0;
            quo           <= '0;
            rem           <= '0;
            dvs           <= '0;
            cnt           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.rd_o      <= '0;
        end else if (bus.flush) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (bus.in_valid) begin
                    op_q     <= bus.op;
                    bus.rd_o <= bus.rd_i;
                    if (!bus.op[2]) begin
                        if (MUL_STAGES == 1) begin
                            bus.result    <= (bus.op == 3'd0) ? prod_in[XLEN-1:0] : prod_in[2*XLEN-1:XLEN];
                            bus.out_valid <= 1'b1;
                            state         <= S_DONE;
                        end else begin
                            prod  <= prod_in;
                            cnt   <= CW'(MUL_STAGES - 2);
                            state <= S_MUL;
                        end
                    end else if (bus.rs2 == '0) begin
                        bus.result    <= bus.op[1] ? bus.rs1 : '1;
                        bus.out_valid <= 1'b1;
                        state         <= S_DONE;
                    end else if (signed_div && bus.rs1 == MIN_NEG && bus.rs2 == '1) begin
                        bus.result    <= bus.op[1] ? '0 : MIN_NEG;
                        bus.out_valid <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        dvs   <= mag_b;
                        rem   <= '0;
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
`ifdef MULDIV_EARLY_OUT_EN
                        quo   <= mag_a << clz(mag_a);
                        cnt   <= CW'(XLEN - clz(mag_a));
                        state <= (mag_a == '0) ? S_FIX : S_DIV;
`else
                        quo   <= mag_a;
                        cnt   <= CW'(XLEN);
                        state <= S_DIV;
`endif
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        bus.result    <= (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                        bus.out_valid <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    rem <= step_ge ? rem_diff : rem_sh[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], step_ge};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (op_q[1]) bus.result <= neg_r ? -rem : rem;
                    else         bus.result <= neg_q ? -quo : quo;
                    bus.out_valid <= 1'b1;
                    state         <= S_DONE;
                end
                S_DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
